binary_erode_3x3: RTL and testbench

//  Streaming 3x3 morphological erosion of the binary mask produced by the threshold stages.

---
 rtl/binary_erode_3x3.sv | 178 +++++++++++++++++
 tb/tb_binary_erode_3x3.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_erode_3x3.sv
// Streaming 3x3 binary erosion of a raster-order 0/255 mask, outside-frame neighbours = background.
// Define MORPH_DILATE_EN to add a per-pixel mode input selecting dilation (mode=1).
module binary_erode_3x3 #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_sof,
`ifdef MORPH_DILATE_EN
    input  logic       mode,
`endif
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_sof
);

    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    // Row counter runs two lines past the frame while flushing.
    localparam int YCW = YW + 1;

    localparam logic [XW-1:0]  XLAST  = XW'(IMG_W - 1);
    localparam logic [YCW-1:0] YLAST  = YCW'(IMG_H - 1);
    localparam logic [YCW-1:0] YFLUSH = YCW'(IMG_H + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q, x_d, px, cx_d, cx_q;
    logic [YCW-1:0]   y_q, y_d, py, cy_d, cy_q;
    logic             take, sof_take, pix, out_en, abort;
    logic [IMG_W-1:0] lb1_q, lb2_q;
    logic [2:0]       w_top_q, w_mid_q, w_bot_q;
    logic             pend_q, valid_q, sof_q;
    logic [7:0]       dout_q;
    logic             lv, rv, tv, bv, erode, result;
    logic [6:0]       unused_din;

    assign unused_din = din[6:0];

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        sof_take = 1'b0;
        pix      = 1'b0;
        case (state_q)
            StIdle: begin
                if (din_valid && din_sof) begin
                    take     = 1'b1;
                    sof_take = 1'b1;
                    pix      = din[7];
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (din_valid) begin
                    take     = 1'b1;
                    sof_take = din_sof;
                    pix      = din[7];
                end
            end
            StFlush: take = 1'b1;
            default: state_d = StIdle;
        endcase

        px = sof_take ? '0 : x_q;
        py = sof_take ? '0 : y_q;

        x_d = x_q;
        y_d = y_q;
        if (take) begin
            if (px == XLAST) begin
                x_d = '0;
                y_d = py + YCW'(1);
            end else begin
                x_d = px + XW'(1);
                y_d = py;
            end
        end

        if (state_q == StRun && take && px == XLAST && py == YLAST) begin
            state_d = StFlush;
        end
        if (state_q == StFlush && py == YFLUSH) begin
            state_d = StIdle;
        end

        // The newest pixel is the bottom-right of the window; the centre trails it by IMG_W+1.
        out_en = take && ((py >= YCW'(2)) || (py == YCW'(1) && px != '0));
        cx_d   = (px == '0) ? XLAST : px - XW'(1);
        cy_d   = (px == '0) ? py - YCW'(2) : py - YCW'(1);
    end

    assign abort = (state_q == StRun) && din_valid && din_sof;

    // Window bit 2 is the left column, bit 0 the right column.
    assign lv    = (cx_q != '0);
    assign rv    = (cx_q != XLAST);
    assign tv    = (cy_q != '0);
    assign bv    = (cy_q != YLAST);
    assign erode = (&w_top_q) & (&w_mid_q) & (&w_bot_q) & lv & rv & tv & bv;

`ifdef MORPH_DILATE_EN
    logic [IMG_W-1:0] mlb_q;
    logic             m1_q, m2_q;
    logic [2:0]       col_mask, top_m, mid_m, bot_m;
    logic             dilate;

    assign col_mask = {lv, 1'b1, rv};
    assign top_m    = w_top_q & col_mask & {3{tv}};
    assign mid_m    = w_mid_q & col_mask;
    assign bot_m    = w_bot_q & col_mask & {3{bv}};
    assign dilate   = |{top_m, mid_m, bot_m};
    assign result   = m2_q ? dilate : erode;

    // Mode is delayed one line plus one pixel so it stays aligned with the window centre.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mlb_q <= '0;
            m1_q  <= 1'b0;
            m2_q  <= 1'b0;
        end else if (take) begin
            m1_q      <= mlb_q[px];
            m2_q      <= m1_q;
            mlb_q[px] <= (state_q == StFlush) ? 1'b0 : mode;
        end
    end
`else
    assign result = erode;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            lb1_q   <= '0;
            lb2_q   <= '0;
            w_top_q <= '0;
            w_mid_q <= '0;
            w_bot_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pend_q  <= out_en;
            if (take) begin
                w_top_q   <= {w_top_q[1:0], lb2_q[px]};
                w_mid_q   <= {w_mid_q[1:0], lb1_q[px]};
                w_bot_q   <= {w_bot_q[1:0], pix};
                lb2_q[px] <= lb1_q[px];
                lb1_q[px] <= pix;
                cx_q      <= cx_d;
                cy_q      <= cy_d;
            end
            // A sof in RUN also kills the old frame's output still in the pipeline.
            valid_q <= pend_q & ~abort;
            sof_q   <= pend_q & ~abort & (cx_q == '0) & (cy_q == '0);
            dout_q  <= (pend_q && result) ? 8'd255 : 8'd0;
        end
    end

    assign din_ready  = (state_q != StFlush);
    assign dout       = dout_q;
    assign dout_valid = valid_q & ~abort;
    assign dout_sof   = sof_q & ~abort;

endmodule

// File: tb/tb_binary_erode_3x3.sv
// Scoreboard bench for binary_erode_3x3 (8x6 frames) against a window-level reference model.
module tb_binary_erode_3x3;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_sof = 1'b0;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_sof;
`ifdef MORPH_DILATE_EN
    logic       mode = 1'b0;
`endif

    binary_erode_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
`ifdef MORPH_DILATE_EN
        .mode       (mode),
`endif
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  out_cnt = 0;
    int  sof_cnt = 0;
    int  sof_out_cyc = 0;
    int  sof_cyc = 0;
    int  frame_out0 = 0;
    int  frame_sof0 = 0;
    bit  img [0:H-1][0:W-1];
    bit  cur_mode = 1'b0;

    // Expected {sof, dout} for output raster index k, straight from the neighbourhood rule.
    function automatic logic [8:0] ref_px(input int k);
        int  x, y, nx, ny;
        bit  all_fg, any_fg, v;
        x = k % W;
        y = k / W;
        all_fg = 1'b1;
        any_fg = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                v = (nx >= 0 && nx < W && ny >= 0 && ny < H) ? img[ny][nx] : 1'b0;
                all_fg &= v;
                any_fg |= v;
            end
        end
        return {(k == 0), ((cur_mode ? any_fg : all_fg) ? 8'd255 : 8'd0)};
    endfunction

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    function automatic logic [7:0] pixbyte(input bit fg);
        logic [7:0] low;
        low = 8'($urandom_range(0, 127));
        return fg ? (8'd128 | low) : low;
    endfunction

    task automatic fill(input int dens);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ($urandom_range(0, 99) < dens);
    endtask

    task automatic fill_block(input int x0, input int x1, input int y0, input int y1);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
    endtask

    // Monitor: pops one expectation per output pulse.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                out_cnt++;
                if (dout_sof === 1'b1) begin
                    sof_cnt++;
                    sof_out_cyc = cyc;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got dout=%0d sof=%0b required none",
                             dout, dout_sof);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_sof, dout} !== e) begin
                        errors++;
                        $display("FAIL out_pixel got dout=%0d sof=%0b required dout=%0d sof=%0b",
                                 dout, dout_sof, e[7:0], e[8]);
                    end
                end
            end
        end
    end

    task automatic send_pixels(input int n, input int gap, input bit abort_chk);
        int b;
        for (int p = 0; p < n; p++) begin
            while ($urandom_range(0, 99) < gap) begin
                @(posedge clk);
                #1;
            end
            b = 0;
            while (!din_ready && b < 100) begin
                @(posedge clk);
                #1;
                b++;
            end
            if (b >= 100) chk("ready_timeout", b, 0);
            din       = pixbyte(img[p / W][p % W]);
            din_sof   = (p == 0);
            din_valid = 1'b1;
`ifdef MORPH_DILATE_EN
            mode      = cur_mode;
`endif
            if (p == 0) begin
                if (abort_chk) begin
                    #1;
                    chk("abort_valid_same_cycle", int'(dout_valid), 0);
                    chk("abort_old_pending", exp_q.size(), 2);
                    exp_q.delete();
                end
                frame_out0 = out_cnt;
                frame_sof0 = sof_cnt;
            end
            if (p >= W + 1) exp_q.push_back(ref_px(p - W - 1));
            @(posedge clk);
            #1;
            if (p == 0) sof_cyc = cyc;
            din_valid = 1'b0;
            din_sof   = 1'b0;
        end
    endtask

    task automatic finish_frame(input bit lat_chk);
        int low;
        for (int k = N - W - 1; k < N; k++) exp_q.push_back(ref_px(k));
        low = 0;
        while (!din_ready && low < 50) begin
            low++;
            @(posedge clk);
            #1;
        end
        chk("flush_ready_low_cycles", low, W + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("frame_output_count", out_cnt - frame_out0, N);
        chk("frame_sof_count", sof_cnt - frame_sof0, 1);
        chk("queue_drained", exp_q.size(), 0);
        if (lat_chk) chk("first_output_latency", sof_out_cyc - sof_cyc, W + 2);
    endtask

    task automatic run_frame(input int gap, input bit lat_chk);
        send_pixels(N, gap, 1'b0);
        finish_frame(lat_chk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", int'(dout), 0);
        chk("reset_dout_valid", int'(dout_valid), 0);
        chk("reset_dout_sof", int'(dout_sof), 0);
        chk("reset_din_ready", int'(din_ready), 1);
        rst_n = 1'b1;

        // Pixels without sof in IDLE must be dropped silently.
        din_valid = 1'b1;
        din       = 8'd255;
        repeat (5) @(posedge clk);
        #1;
        din_valid = 1'b0;
        chk("idle_ready", int'(din_ready), 1);
        repeat (20) @(posedge clk);
        #1;

        fill(100);
        run_frame(0, 1'b1);

        fill(0);
        img[2][3] = 1'b1;
        run_frame(0, 1'b0);

        fill_block(2, 5, 1, 4);
        run_frame(0, 1'b0);

        // Foreground on both frame edges of rows 1..4: nothing may survive across the wrap.
        fill(0);
        for (int y = 1; y <= 4; y++) begin
            img[y][0] = 1'b1;
            img[y][1] = 1'b1;
            img[y][6] = 1'b1;
            img[y][7] = 1'b1;
        end
        run_frame(0, 1'b0);

        fill_block(2, 5, 1, 4);
        run_frame(50, 1'b0);

        for (int i = 0; i < 4; i++) begin
            fill(85);
            run_frame($urandom_range(0, 60), 1'b0);
        end

        // sof re-asserted at pixel 20 of a running frame.
        fill(90);
        send_pixels(20, 0, 1'b0);
        fill(100);
        send_pixels(N, 0, 1'b1);
        finish_frame(1'b0);

        // One-cycle reset at pixel 30.
        fill_block(1, 6, 1, 4);
        send_pixels(30, 0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_dout_valid", int'(dout_valid), 0);
        chk("midreset_dout_sof", int'(dout_sof), 0);
        chk("midreset_din_ready", int'(din_ready), 1);
        exp_q.delete();
        rst_n = 1'b1;
        run_frame(20, 1'b0);

`ifdef MORPH_DILATE_EN
        cur_mode = 1'b1;
        fill(0);
        img[2][3] = 1'b1;
        run_frame(0, 1'b0);
        fill(10);
        run_frame(30, 1'b0);
        cur_mode = 1'b0;
        fill(85);
        run_frame(0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
